// File: rtl/core_pkg.sv
// Shared core constants and types used by the pipeline stages.
package core_pkg;

    localparam int DATA_WIDTH     = 32;
    localparam int REG_ADDR_WIDTH = 5;

    // Load funct3 encodings
    localparam logic [2:0] FUNCT3_LOAD_BYTE   = 3'b000;
    localparam logic [2:0] FUNCT3_LOAD_HALF   = 3'b001;
    localparam logic [2:0] FUNCT3_LOAD_WORD   = 3'b010;
    localparam logic [2:0] FUNCT3_LOAD_BYTE_U = 3'b100;
    localparam logic [2:0] FUNCT3_LOAD_HALF_U = 3'b101;

    // Write-back source select; 2'b11 is unused and selects zero
    typedef enum logic [1:0] {
        WB_ALU = 2'b00,
        WB_MEM = 2'b01,
        WB_PC4 = 2'b10
    } wb_sel_e;

endpackage

// File: rtl/load_extender.sv
// Combinational load alignment: picks the byte/half/word addressed by the
// low address bits out of the raw memory word and sign/zero-extends it.
module load_extender
    import core_pkg::*;
#(
    parameter int DATA_WIDTH = core_pkg::DATA_WIDTH
) (
    input  logic [DATA_WIDTH-1:0] i_word,
    input  logic [1:0]            i_addr,
    input  logic [2:0]            i_funct3,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_misaligned,
    output logic                  o_unsupported
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Byte and half-word lane selection from the address offset
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        w_byte = i_word[7:0];
        case (i_addr)
            2'd0: w_byte = i_word[7:0];
            2'd1: w_byte = i_word[15:8];
            2'd2: w_byte = i_word[23:16];
            2'd3: w_byte = i_word[31:24];
            default: w_byte = i_word[7:0];
        endcase
        w_half = i_addr[1] ? i_word[31:16] : i_word[15:0];
    end

    // Extension by load type, plus alignment and legality checks
    always_comb begin
        o_data        = '0;
        o_misaligned  = 1'b0;
        o_unsupported = 1'b0;
        case (i_funct3)
            FUNCT3_LOAD_BYTE:   o_data = {{(DATA_WIDTH-8){w_byte[7]}}, w_byte};
            FUNCT3_LOAD_BYTE_U: o_data = {{(DATA_WIDTH-8){1'b0}}, w_byte};
            FUNCT3_LOAD_HALF: begin
                o_data       = {{(DATA_WIDTH-16){w_half[15]}}, w_half};
                o_misaligned = i_addr[0];
            end
            FUNCT3_LOAD_HALF_U: begin
                o_data       = {{(DATA_WIDTH-16){1'b0}}, w_half};
                o_misaligned = i_addr[0];
            end
            FUNCT3_LOAD_WORD: begin
                o_data       = i_word;
                o_misaligned = (i_addr != 2'b00);
            end
            default: o_unsupported = 1'b1;
        endcase
    end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register: selects the write-back value, aligns load data,
// flags misaligned loads and drives the register-file write port.
module mem_wb_stage
    import core_pkg::*;
#(
    parameter int DATA_WIDTH     = core_pkg::DATA_WIDTH,
    parameter int REG_ADDR_WIDTH = core_pkg::REG_ADDR_WIDTH
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      stall_i,
    input  logic                      flush_i,
    input  logic                      valid_i,
    input  logic                      RegWrite_i,
    input  logic                      MemRead_i,
    input  logic [1:0]                wb_sel_i,
    input  logic [2:0]                funct3_i,
    input  logic [REG_ADDR_WIDTH-1:0] rd_addr_i,
    input  logic [DATA_WIDTH-1:0]     alu_result_i,
    input  logic [DATA_WIDTH-1:0]     mem_rd_data_i,
    input  logic [DATA_WIDTH-1:0]     pc_plus4_i,
    output logic                      valid_o,
    output logic                      RegWrite_o,
    output logic [REG_ADDR_WIDTH-1:0] rd_addr_o,
    output logic [DATA_WIDTH-1:0]     rd_wr_data_o,
    output logic                      load_misaligned_o
);

    logic [DATA_WIDTH-1:0]     w_load_data;
    logic                      w_ext_misaligned;
    logic                      w_ext_unsupported;
    logic                      w_misaligned;
    logic                      w_unsupported_load;
    logic                      w_reg_write;
    logic [DATA_WIDTH-1:0]     w_wb_data;

    logic                      r_valid;
    logic                      r_reg_write;
    logic [REG_ADDR_WIDTH-1:0] r_rd_addr;
    logic [DATA_WIDTH-1:0]     r_rd_wr_data;
    logic                      r_load_misaligned;

    load_extender #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_load_extender (
        .i_word       (mem_rd_data_i),
        .i_addr       (alu_result_i[1:0]),
        .i_funct3     (funct3_i),
        .o_data       (w_load_data),
        .o_misaligned (w_ext_misaligned),
        .o_unsupported(w_ext_unsupported)
    );

    // Qualify the extender flags with the instruction actually being a valid load
    always_comb begin
        w_misaligned       = MemRead_i & valid_i & w_ext_misaligned;
        w_unsupported_load = MemRead_i & w_ext_unsupported;
        w_reg_write        = RegWrite_i & valid_i & (rd_addr_i != '0)
                             & ~w_misaligned & ~w_unsupported_load;
    end

    // Write-back source mux
    always_comb begin
        w_wb_data = '0;
        case (wb_sel_i)
            WB_ALU:  w_wb_data = alu_result_i;
            WB_MEM:  w_wb_data = w_load_data;
            WB_PC4:  w_wb_data = pc_plus4_i;
            default: w_wb_data = '0;
        endcase
    end

    // Pipeline register: flush beats stall, stall holds, otherwise capture
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (!rst_n) begin
            r_valid           <= 1'b0;
            r_reg_write       <= 1'b0;
            r_rd_addr         <= '0;
            r_rd_wr_data      <= '0;
            r_load_misaligned <= 1'b0;
        end else if (flush_i) begin
            r_valid           <= 1'b0;
            r_reg_write       <= 1'b0;
            r_rd_addr         <= '0;
            r_rd_wr_data      <= '0;
            r_load_misaligned <= 1'b0;
        end else if (!stall_i) begin
            r_valid           <= valid_i;
            r_reg_write       <= w_reg_write;
            r_rd_addr         <= rd_addr_i;
            r_rd_wr_data      <= w_wb_data;
            r_load_misaligned <= w_misaligned;
        end
    end

    assign valid_o           = r_valid;
    assign RegWrite_o        = r_reg_write;
    assign rd_addr_o         = r_rd_addr;
    assign rd_wr_data_o      = r_rd_wr_data;
    assign load_misaligned_o = r_load_misaligned;

endmodule
